// File: rtl/mat_pkg.sv
// Shared definitions for the lane-parallel matrix add/sub/accumulate block:
// op encodings, default geometry and the lane-slice helper.
package mat_pkg;

    localparam int DEF_LANES = 16;
    localparam int DEF_W     = 16;

    typedef enum logic [1:0] {
        OP_ADD      = 2'b00,
        OP_SUB      = 2'b01,
        OP_ACC_ADD  = 2'b10,
        OP_ACC_LOAD = 2'b11
    } op_e;

    // Lane i occupies bits [i*width +: width] of a packed row-major vector.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mat_lane_alu.sv
// One lane of the matrix datapath: W+1-bit signed add/sub/accumulate with
// overflow detection and optional signed saturation. Purely combinational.
module mat_lane_alu
    import mat_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int SAT = 0
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] acc,
    output logic [W-1:0] result,
    output logic         ovf
);

    logic signed [W:0] a_x;
    logic signed [W:0] b_x;
    logic signed [W:0] acc_x;
    logic signed [W:0] r;

    assign a_x   = {a[W-1], a};
    assign b_x   = {b[W-1], b};
    assign acc_x = {acc[W-1], acc};

    // NOTE: every output of an always_comb gets a value before any branch,
    // so no path through the case can leave a latch behind.
    always_comb begin
        r      = a_x;
        result = a;
        ovf    = 1'b0;

        case (op_e'(op))
            OP_ADD:      r = a_x + b_x;
            OP_SUB:      r = a_x - b_x;
            OP_ACC_ADD:  r = acc_x + a_x;
            OP_ACC_LOAD: r = a_x;
            default:     r = a_x;
        endcase

        // The W+1-bit sum is out of W-bit range exactly when its top two bits differ.
        ovf = (r[W] != r[W-1]);

        if (SAT != 0 && ovf) begin
            result = r[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            result = r[W-1:0];
        end
    end

endmodule

// File: rtl/matrix_add_sub_acc.sv
// Lane-parallel matrix adder/subtractor/accumulator with valid/ready on both
// sides, a one-beat output register and a per-lane accumulator bank.
module matrix_add_sub_acc
    import mat_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int W     = DEF_W,
    parameter int SAT   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [LANES*W-1:0] dataa,
    input  logic [LANES*W-1:0] datab,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] result,
    output logic [LANES-1:0]   ovf
);

    logic [LANES*W-1:0] acc;
    logic [LANES*W-1:0] lane_result;
    logic [LANES-1:0]   lane_ovf;
    logic               accept;
    logic               acc_write;

    // The output register can take a new beat when empty or being drained.
    assign in_ready  = !reset && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign acc_write = (op == OP_ACC_ADD) || (op == OP_ACC_LOAD);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mat_lane_alu #(
            .W   (W),
            .SAT (SAT)
        ) u_alu (
            .op     (op),
            .a      (dataa[lane_lsb(i, W) +: W]),
            .b      (datab[lane_lsb(i, W) +: W]),
            .acc    (acc[lane_lsb(i, W) +: W]),
            .result (lane_result[lane_lsb(i, W) +: W]),
            .ovf    (lane_ovf[i])
        );
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= '0;
            // NOTE: the accumulator bank is a flop array, not a RAM, because
            // it must read back as zero after reset.
            acc       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= lane_result;
            ovf       <= lane_ovf;
            if (acc_write) begin
                acc <= lane_result;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matrix_add_sub_acc.sv
// Self-checking bench: a wrap and a saturating instance driven in lockstep,
// checked against an integer-arithmetic model every cycle plus directed literals.
module tb_matrix_add_sub_acc;

    localparam int LANES = 16;
    localparam int W     = 16;
    localparam int LW    = LANES * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [1:0]    op;
    logic [LW-1:0] dataa;
    logic [LW-1:0] datab;
    logic          out_ready;

    logic             in_ready [2];
    logic             out_valid[2];
    logic [LW-1:0]    result   [2];
    logic [LANES-1:0] ovf      [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matrix_add_sub_acc #(.LANES(LANES), .W(W), .SAT(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
        .op(op), .dataa(dataa), .datab(datab), .out_valid(out_valid[0]),
        .out_ready(out_ready), .result(result[0]), .ovf(ovf[0])
    );

    matrix_add_sub_acc #(.LANES(LANES), .W(W), .SAT(1)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
        .op(op), .dataa(dataa), .datab(datab), .out_valid(out_valid[1]),
        .out_ready(out_ready), .result(result[1]), .ovf(ovf[1])
    );

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] lane(input logic [LW-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    // ---------------- behavioural model ----------------
    int            acc_m [2][LANES];
    logic [LW-1:0] exp_res[2];
    logic [LANES-1:0] exp_ovf[2];
    logic          exp_valid = 1'b0;
    logic          res_known = 1'b0;
    logic          live      = 1'b0;

    function automatic void lane_model(input int sat, input logic [1:0] o,
                                       input logic [W-1:0] a, input logic [W-1:0] b,
                                       input int acc_v, output logic [W-1:0] res,
                                       output logic ov);
        int sa;
        int sb;
        int r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (o)
            2'd0:    r = sa + sb;
            2'd1:    r = sa - sb;
            2'd2:    r = acc_v + sa;
            default: r = sa;
        endcase
        ov = (r > 32767) || (r < -32768);
        if (sat != 0 && ov) res = (r > 0) ? 16'h7FFF : 16'h8000;
        else                res = r[W-1:0];
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset) begin
            live      = 1'b1;
            exp_valid = 1'b0;
            res_known = 1'b1;
            for (int k = 0; k < 2; k++) begin
                exp_res[k] = '0;
                exp_ovf[k] = '0;
                for (int l = 0; l < LANES; l++) acc_m[k][l] = 0;
            end
        end else if (in_valid && (!exp_valid || out_ready)) begin
            exp_valid = 1'b1;
            res_known = 1'b1;
            for (int k = 0; k < 2; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    logic [W-1:0] rv;
                    logic         ov;
                    lane_model(k, op, dataa[l*W +: W], datab[l*W +: W], acc_m[k][l], rv, ov);
                    exp_res[k][l*W +: W] = rv;
                    exp_ovf[k][l]        = ov;
                    if (op[1]) acc_m[k][l] = int'($signed(rv));
                end
            end
        end else if (out_ready) begin
            exp_valid = 1'b0;
            res_known = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("cmp_in_ready[%0d]", k), LW'(in_ready[k]),
                      LW'(!reset && (!exp_valid || out_ready)));
                check($sformatf("cmp_out_valid[%0d]", k), LW'(out_valid[k]), LW'(exp_valid));
                if (res_known) begin
                    check($sformatf("cmp_result[%0d]", k), result[k], exp_res[k]);
                    check($sformatf("cmp_ovf[%0d]", k), LW'(ovf[k]), LW'(exp_ovf[k]));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] o, input logic [W-1:0] a0, input logic [W-1:0] b0);
        op       = o;
        dataa    = '0;
        datab    = '0;
        dataa[W-1:0] = a0;
        datab[W-1:0] = b0;
        in_valid = 1'b1;
    endtask

    int  n_acc;
    int  n_xfer;
    int  cycles;
    logic acc_now;
    logic xfer_now;

    initial begin
        reset = 1'b1; in_valid = 1'b0; op = 2'd0; dataa = '0; datab = '0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", LW'(out_valid[0]), '0);
        check("rst_result", result[0], '0);
        check("rst_ovf", LW'(ovf[0]), '0);
        check("rst_in_ready", LW'(in_ready[0]), '0);
        reset = 1'b0;

        // ADD with lane 15 wrapping to zero
        beat(2'd0, 16'h0003, 16'h0004);
        dataa[15*W +: W] = 16'hFFFF;
        datab[15*W +: W] = 16'h0001;
        tick();
        check("add_valid", LW'(out_valid[0]), LW'(1));
        check("add_lane0", LW'(lane(result[0], 0)), LW'(16'h0007));
        check("add_lane15", LW'(lane(result[0], 15)), LW'(16'h0000));
        check("add_ovf", LW'(ovf[0]), '0);

        // SUB: lane0 0-1, lane1 0x8000-1 (negative overflow)
        beat(2'd1, 16'h0000, 16'h0001);
        dataa[W +: W] = 16'h8000;
        datab[W +: W] = 16'h0001;
        tick();
        check("sub_lane0", LW'(lane(result[0], 0)), LW'(16'hFFFF));
        check("sub_ovf0", LW'(ovf[0][0]), '0);
        check("sub_wrap_lane1", LW'(lane(result[0], 1)), LW'(16'h7FFF));
        check("sub_sat_lane1", LW'(lane(result[1], 1)), LW'(16'h8000));
        check("sub_sat_ovf1", LW'(ovf[1][1]), LW'(1));

        // ADD positive overflow
        beat(2'd0, 16'h7FFF, 16'h0001);
        tick();
        check("ovf_wrap_lane0", LW'(lane(result[0], 0)), LW'(16'h8000));
        check("ovf_wrap_flag", LW'(ovf[0][0]), LW'(1));
        check("ovf_sat_lane0", LW'(lane(result[1], 0)), LW'(16'h7FFF));
        check("ovf_sat_flag", LW'(ovf[1][0]), LW'(1));

        // accumulate chain
        beat(2'd3, 16'd5, 16'd0); tick();
        check("acc_load", LW'(lane(result[0], 0)), LW'(16'd5));
        beat(2'd2, 16'd3, 16'd0); tick();
        check("acc_add3", LW'(lane(result[0], 0)), LW'(16'd8));
        beat(2'd2, 16'd2, 16'd0); tick();
        check("acc_add2", LW'(lane(result[0], 0)), LW'(16'd10));
        beat(2'd0, 16'd1, 16'd1); tick();
        check("acc_plain_add", LW'(lane(result[0], 0)), LW'(16'd2));
        beat(2'd2, 16'd0, 16'd0); tick();
        check("acc_after_add", LW'(lane(result[0], 0)), LW'(16'd10));

        // backpressure
        beat(2'd0, 16'd3, 16'd4); tick();
        out_ready = 1'b0;
        beat(2'd2, 16'd9, 16'd0);
        #1;
        check("bp_in_ready", LW'(in_ready[0]), '0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_hold_valid", LW'(out_valid[0]), LW'(1));
            check("bp_hold_result", LW'(lane(result[0], 0)), LW'(16'h0007));
            check("bp_hold_ready", LW'(in_ready[0]), '0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release", LW'(lane(result[0], 0)), LW'(16'd19));
        in_valid = 1'b0;
        tick();
        check("bp_drained", LW'(out_valid[0]), '0);
        beat(2'd2, 16'd0, 16'd0); tick();
        check("bp_once", LW'(lane(result[0], 0)), LW'(16'd19));

        // reset mid-stream with a result pending
        reset = 1'b1;
        beat(2'd2, 16'd7, 16'd0);
        tick();
        check("mid_rst_valid", LW'(out_valid[0]), '0);
        check("mid_rst_result", result[0], '0);
        reset = 1'b0;
        tick();
        check("post_rst_acc", LW'(lane(result[0], 0)), LW'(16'd7));
        in_valid = 1'b0;
        tick();

        // streaming with random backpressure
        n_acc = 0; n_xfer = 0; cycles = 0;
        while (n_acc < 100 && cycles < 3000) begin
            if (!in_valid && $urandom_range(3) != 0) begin
                op = 2'($urandom_range(1));
                for (int l = 0; l < LANES; l++) begin
                    dataa[l*W +: W] = W'($urandom);
                    datab[l*W +: W] = W'($urandom);
                end
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(1));
            #1;
            acc_now  = in_valid && in_ready[0];
            xfer_now = out_valid[0] && out_ready;
            tick();
            if (acc_now) begin
                n_acc++;
                in_valid = 1'b0;
            end
            if (xfer_now) n_xfer++;
            cycles++;
        end
        check("stream_beats", LW'(n_acc), LW'(100));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        if (out_valid[0]) n_xfer++;
        tick();
        check("stream_xfers", LW'(n_xfer), LW'(n_acc));
        check("stream_idle", LW'(out_valid[0]), '0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
